// File: rtl/iop_rst_pkg.sv
// iop_rst_pkg: shared encodings and default timing for the IOP reset sequencer.
// Imported by iop_rst_sync and iop_rst_seq.
package iop_rst_pkg;

    localparam logic [1:0] SEQ_ST_RESET = 2'b00;
    localparam logic [1:0] SEQ_ST_SEQ   = 2'b01;
    localparam logic [1:0] SEQ_ST_DONE  = 2'b10;
    localparam logic [1:0] SEQ_ST_WARM  = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET = SEQ_ST_RESET,
        ST_SEQ   = SEQ_ST_SEQ,
        ST_DONE  = SEQ_ST_DONE,
        ST_WARM  = SEQ_ST_WARM
    } state_e;

    localparam int DEF_NUM_CORES = 1;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_CKEN_DLY  = 20;
    localparam int DEF_PRE_DLY   = 60;
    localparam int DEF_GRST_DLY  = 120;
    localparam int DEF_STAGGER   = 0;
    localparam int DEF_DONE_DLY  = 254;
    localparam int DEF_WARM_LEN  = 16;

endpackage

// File: rtl/iop_rst_sync.sv
// iop_rst_sync: 2-flop reset synchroniser, async assert / sync deassert.
// ACTIVE_HIGH inverts the raw pin before it reaches the flops.
module iop_rst_sync
    import iop_rst_pkg::*;
#(
    parameter bit ACTIVE_HIGH = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_n_o
);

    logic       arst_n;
    logic [1:0] sync_q;

    assign arst_n = ACTIVE_HIGH ? ~rst_i : rst_i;

    // Shift a 1 in after release; clear both stages at once on assert.
    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_n_o = sync_q[1];

endmodule

// File: rtl/iop_rst_seq.sv
// iop_rst_seq: multi-core bring-up reset sequencer on gclk.
// Optional warm reset is built when IOP_RST_SEQ_WARM_EN is defined.
module iop_rst_seq
    import iop_rst_pkg::*;
#(
    parameter int NUM_CORES        = DEF_NUM_CORES,
    parameter int CNT_W            = DEF_CNT_W,
    parameter int CKEN_DLY         = DEF_CKEN_DLY,
    parameter int PRE_DLY          = DEF_PRE_DLY,
    parameter int GRST_DLY         = DEF_GRST_DLY,
    parameter int STAGGER          = DEF_STAGGER,
    parameter int DONE_DLY         = DEF_DONE_DLY,
    parameter int WARM_LEN         = DEF_WARM_LEN,
    parameter int C_EXT_RESET_HIGH = 0
) (
    input  logic                 gclk,
    input  logic                 reset_l,
    input  logic [NUM_CORES-1:0] core_en,
    input  logic                 warm_rst_req,
    output logic                 cmp_arst_l,
    output logic                 adbginit_l,
    output logic [NUM_CORES-1:0] cluster_cken,
    output logic [NUM_CORES-1:0] ctu_tst_pre_grst_l,
    output logic [NUM_CORES-1:0] cmp_grst_l,
    output logic [NUM_CORES-1:0] gdbginit_l,
    output logic                 reset_done,
    output logic [1:0]           seq_state
);

    if (NUM_CORES < 1 || NUM_CORES > 8) begin : g_chk_cores
        $error("iop_rst_seq: NUM_CORES must be 1..8");
    end
    if (!(CKEN_DLY < PRE_DLY && PRE_DLY < GRST_DLY)) begin : g_chk_order
        $error("iop_rst_seq: need CKEN_DLY < PRE_DLY < GRST_DLY");
    end
    if (!(GRST_DLY + (NUM_CORES - 1) * STAGGER < DONE_DLY)) begin : g_chk_stag
        $error("iop_rst_seq: last core grst must precede DONE_DLY");
    end
    if (longint'(DONE_DLY) + 1 > (longint'(1) << CNT_W) - 1) begin : g_chk_w
        $error("iop_rst_seq: DONE_DLY+1 does not fit CNT_W");
    end

    localparam logic [CNT_W-1:0] CKEN_C    = CNT_W'(CKEN_DLY);
    localparam logic [CNT_W-1:0] PRE_C     = CNT_W'(PRE_DLY);
    localparam logic [CNT_W-1:0] DONE_C    = CNT_W'(DONE_DLY);
    localparam logic [CNT_W-1:0] HOLD_C    = CNT_W'(DONE_DLY + 1);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_LEN - 1);
    localparam logic [CNT_W-1:0] REPLAY_C  = CNT_W'(CKEN_DLY + 1);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic                 rst_int;
    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [NUM_CORES-1:0] en_q;
    logic                 run;
    logic                 warm;

    iop_rst_sync #(
        .ACTIVE_HIGH(C_EXT_RESET_HIGH != 0)
    ) u_sync (
        .clk_i  (gclk),
        .rst_i  (reset_l),
        .rst_n_o(rst_int)
    );

`ifndef IOP_RST_SEQ_WARM_EN
    logic unused_warm;
    assign unused_warm = warm_rst_req;
`endif

    // Sequencer FSM: counter, state and captured core enables.
    always_ff @(posedge gclk or negedge rst_int) begin
        if (!rst_int) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            en_q    <= '0;
        end else begin
            unique case (state_q)
                ST_RESET: begin
                    state_q <= ST_SEQ;
                    cnt_q   <= '0;
                    en_q    <= core_en;
                end
                ST_SEQ: begin
                    if (cnt_q >= DONE_C) begin
                        state_q <= ST_DONE;
                        cnt_q   <= HOLD_C;
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
                end
                ST_DONE: begin
`ifdef IOP_RST_SEQ_WARM_EN
                    if (warm_rst_req) begin
                        state_q <= ST_WARM;
                        cnt_q   <= '0;
                        en_q    <= core_en;
                    end
`endif
                end
                ST_WARM: begin
`ifdef IOP_RST_SEQ_WARM_EN
                    if (cnt_q >= WARM_LAST) begin
                        state_q <= ST_SEQ;
                        cnt_q   <= REPLAY_C;
                    end else begin
                        cnt_q <= cnt_q + ONE_C;
                    end
`else
                    state_q <= ST_RESET;
                    cnt_q   <= '0;
`endif
                end
                default: begin
                    state_q <= ST_RESET;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign run  = (state_q == ST_SEQ) || (state_q == ST_DONE);
    assign warm = (state_q == ST_WARM);

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        localparam logic [CNT_W-1:0] GRST_C = CNT_W'(GRST_DLY + i * STAGGER);

        assign cluster_cken[i] =
            en_q[i] & ((run & (cnt_q > CKEN_C)) | warm);
        assign ctu_tst_pre_grst_l[i] = en_q[i] & run & (cnt_q > PRE_C);
        assign cmp_grst_l[i]         = en_q[i] & run & (cnt_q > GRST_C);
        assign gdbginit_l[i]         = en_q[i] & run & (cnt_q > GRST_C);
    end

    assign cmp_arst_l = rst_int;
    assign adbginit_l = rst_int;
    assign reset_done = (state_q == ST_DONE);
    assign seq_state  = state_q;

endmodule

// File: tb/tb_iop_rst_seq.sv
// tb_iop_rst_seq: scoreboard bench for iop_rst_seq, NUM_CORES=2, STAGGER=4.
// Define IOP_RST_SEQ_WARM_EN for both files to exercise the warm reset.
`timescale 1ns/1ps
module tb_iop_rst_seq;

    logic       gclk = 1'b0;
    logic       reset_l = 1'b0;
    logic [1:0] core_en = 2'b11;
    logic       warm_rst_req = 1'b0;
    logic       cmp_arst_l;
    logic       adbginit_l;
    logic [1:0] cluster_cken;
    logic [1:0] ctu_tst_pre_grst_l;
    logic [1:0] cmp_grst_l;
    logic [1:0] gdbginit_l;
    logic       reset_done;
    logic [1:0] seq_state;

    typedef struct packed {
        logic       arst;
        logic       adbg;
        logic [1:0] cken;
        logic [1:0] pre;
        logic [1:0] grst;
        logic [1:0] gdbg;
        logic       done;
        logic [1:0] st;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    logic [1:0] en_cur = 2'b11;

    iop_rst_seq #(
        .NUM_CORES(2),
        .STAGGER  (4)
    ) dut (
        .gclk              (gclk),
        .reset_l           (reset_l),
        .core_en           (core_en),
        .warm_rst_req      (warm_rst_req),
        .cmp_arst_l        (cmp_arst_l),
        .adbginit_l        (adbginit_l),
        .cluster_cken      (cluster_cken),
        .ctu_tst_pre_grst_l(ctu_tst_pre_grst_l),
        .cmp_grst_l        (cmp_grst_l),
        .gdbginit_l        (gdbginit_l),
        .reset_done        (reset_done),
        .seq_state         (seq_state)
    );

    always #5 gclk = ~gclk;

    function automatic obs_t observe();
        obs_t o;
        o.arst = cmp_arst_l;
        o.adbg = adbginit_l;
        o.cken = cluster_cken;
        o.pre  = ctu_tst_pre_grst_l;
        o.grst = cmp_grst_l;
        o.gdbg = gdbginit_l;
        o.done = reset_done;
        o.st   = seq_state;
        return o;
    endfunction

    // k = gclk edges since reset_l release; cnt = k-3 once in SEQ.
    function automatic obs_t exp_cold(int k, logic [1:0] en);
        obs_t e;
        int   c;
        e = '0;
        e.arst = (k >= 2);
        e.adbg = (k >= 2);
        if (k >= 3) begin
            c = (k - 3 > 255) ? 255 : k - 3;
            e.cken = (c >= 21) ? en : 2'b00;
            e.pre  = (c >= 61) ? en : 2'b00;
            e.grst = {(c >= 125) && en[1], (c >= 121) && en[0]};
            e.gdbg = e.grst;
            e.done = (c >= 255);
            e.st   = (c >= 255) ? 2'b10 : 2'b01;
        end
        return e;
    endfunction

    // m = edges since the edge that accepted the warm request.
    function automatic obs_t exp_warm(int m, logic [1:0] en);
        obs_t e;
        int   c;
        e = '0;
        e.arst = 1'b1;
        e.adbg = 1'b1;
        e.cken = en;
        if (m < 16) begin
            e.st = 2'b11;
        end else begin
            c = (21 + m - 16 > 255) ? 255 : 21 + m - 16;
            e.pre  = (c >= 61) ? en : 2'b00;
            e.grst = {(c >= 125) && en[1], (c >= 121) && en[0]};
            e.gdbg = e.grst;
            e.done = (c >= 255);
            e.st   = (c >= 255) ? 2'b10 : 2'b01;
        end
        return e;
    endfunction

    task automatic hold_reset(int n);
        @(negedge gclk);
        reset_l = 1'b0;
        repeat (n) @(negedge gclk);
    endtask

    task automatic test_reset();
        obs_t got, want;
        hold_reset(1);
        for (int i = 0; i < 3; i++) begin
            @(posedge gclk);
            exp_q.push_back('0);
            @(negedge gclk);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset i=%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic run_cold(string name, int kmax, bit warm_in_seq);
        obs_t got, want;
        reset_l = 1'b1;
        for (int k = 1; k <= kmax; k++) begin
            @(posedge gclk);
            exp_q.push_back(exp_cold(k, en_cur));
            @(negedge gclk);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s k=%0d got=%h want=%h", name, k, got, want);
            end
            if (warm_in_seq) warm_rst_req = (k >= 10 && k < 200);
        end
    endtask

    task automatic test_cold_seq();
        hold_reset(3);
        core_en = 2'b11;
        en_cur  = 2'b11;
        run_cold("cold11", 270, 1'b0);
    endtask

    task automatic test_core_en();
        obs_t got, want;
        hold_reset(3);
        core_en = 2'b01;
        en_cur  = 2'b01;
        run_cold("en01", 270, 1'b1);
        for (int i = 0; i < 8; i++) begin
            core_en = 2'(i);
            @(posedge gclk);
            exp_q.push_back(exp_cold(300, 2'b01));
            @(negedge gclk);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL en_toggle i=%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_midseq_reset();
        obs_t got, want;
        hold_reset(3);
        core_en = 2'b11;
        en_cur  = 2'b11;
        run_cold("pre_abort", 83, 1'b0);
        reset_l = 1'b0;
        #1;
        exp_q.push_back('0);
        got  = observe();
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_abort got=%h want=%h", got, want);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge gclk);
            exp_q.push_back('0);
            @(negedge gclk);
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL abort_hold i=%0d got=%h want=%h", i, got, want);
            end
        end
        run_cold("replay", 270, 1'b0);
    endtask

`ifdef IOP_RST_SEQ_WARM_EN
    task automatic test_warm();
        obs_t got, want;
        warm_rst_req = 1'b1;
        core_en      = 2'b10;
        en_cur       = 2'b10;
        for (int m = 0; m < 16 + 240; m++) begin
            @(posedge gclk);
            exp_q.push_back(exp_warm(m, en_cur));
            @(negedge gclk);
            warm_rst_req = 1'b0;
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL warm m=%0d got=%h want=%h", m, got, want);
            end
        end
    endtask
`else
    task automatic test_warm_ignored();
        obs_t got, want;
        warm_rst_req = 1'b1;
        core_en      = 2'b00;
        for (int i = 0; i < 20; i++) begin
            @(posedge gclk);
            exp_q.push_back(exp_cold(300, en_cur));
            @(negedge gclk);
            warm_rst_req = 1'b0;
            got  = observe();
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL warm_ign i=%0d got=%h want=%h", i, got, want);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_seq();
        test_core_en();
        test_midseq_reset();
`ifdef IOP_RST_SEQ_WARM_EN
        test_warm();
`else
        test_warm_ignored();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
